// File: rtl/sonar_pkg.sv
// Shared types and default timing for the ultrasonic echo emulator and its sensor controller.
package sonar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        RECOVER
    } sonar_state_t;

    localparam int TRIG_MIN_CYC_DEF = 650;
    localparam int BURST_CYC_DEF    = 13000;
    localparam int CYC_PER_CM_DEF   = 3770;
    localparam int TIMEOUT_CYC_DEF  = 2470000;
    localparam int RECOVER_CYC_DEF  = 65000;

    // 22 bits holds the 38 ms timeout and the 255 cm width product
    localparam int CNT_W = 22;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with single-cycle rise/fall pulses on the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic s1, s2, prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign dout = s2;
    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;

endmodule

// File: rtl/sonar_echo_emu.sv
// HC-SR04 style echo emulator: validates trig width, waits the burst time, then echoes distance.
// Optional build macro SONAR_EMU_JITTER_EN adds 0-15 cycles of LFSR jitter to the burst delay.
//
// state   | meaning
// IDLE    | waiting for a trig_s rising edge
// TRIG_HI | measuring trig_s high width (saturating)
// BURST   | emulated transmit burst, echo low
// ECHO    | echo high for the distance-derived width
// RECOVER | dead time, trig ignored
module sonar_echo_emu
    import sonar_pkg::*;
#(
    parameter int TRIG_MIN_CYC = TRIG_MIN_CYC_DEF,
    parameter int BURST_CYC    = BURST_CYC_DEF,
    parameter int CYC_PER_CM   = CYC_PER_CM_DEF,
    parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
    parameter int RECOVER_CYC  = RECOVER_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [7:0] distance_cm,
    output logic       echo,
    output logic       busy
);

    logic trig_s, trig_rise, trig_fall;

    sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (trig),
        .dout (trig_s),
        .rise (trig_rise),
        .fall (trig_fall)
    );

    sonar_state_t     state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       dist_q, dist_n;
    logic [CNT_W-1:0] echo_width;
    logic [CNT_W-1:0] burst_dly;

    assign echo_width = (dist_q == 8'd0) ? CNT_W'(TIMEOUT_CYC)
                                         : CNT_W'(dist_q) * CNT_W'(CYC_PER_CM);

`ifdef SONAR_EMU_JITTER_EN
    logic [7:0] lfsr, lfsr_n;
    assign burst_dly = CNT_W'(BURST_CYC) + CNT_W'(lfsr[3:0]);

    always_ff @(posedge clk) begin
        if (rst) lfsr <= 8'hA5;
        else     lfsr <= lfsr_n;
    end
`else
    assign burst_dly = CNT_W'(BURST_CYC);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            dist_q <= 8'd0;
            echo   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            dist_q <= dist_n;
            echo   <= (state_n == ECHO);
            busy   <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dist_n  = dist_q;
`ifdef SONAR_EMU_JITTER_EN
        lfsr_n  = lfsr;
`endif
        case (state)
            IDLE: begin
                if (trig_rise) begin
                    state_n = TRIG_HI;
                    cnt_n   = CNT_W'(1);
                end
            end
            TRIG_HI: begin
                if (trig_fall) begin
                    if (cnt >= CNT_W'(TRIG_MIN_CYC)) begin
                        state_n = BURST;
                        cnt_n   = burst_dly - 1'b1;
                        dist_n  = distance_cm;
`ifdef SONAR_EMU_JITTER_EN
                        lfsr_n  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else if (cnt < CNT_W'(TRIG_MIN_CYC)) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BURST: begin
                if (cnt == '0) begin
                    state_n = ECHO;
                    cnt_n   = echo_width - 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ECHO: begin
                if (cnt == '0) begin
                    state_n = RECOVER;
                    cnt_n   = CNT_W'(RECOVER_CYC) - 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RECOVER: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sonar_echo_emu.sv
// Bench for sonar_echo_emu: vector table of trig/distance cases plus reset and ignore-trig sequences.
module tb_sonar_echo_emu;

    localparam int TMIN = 65;
    localparam int BST  = 1300;
    localparam int CPC  = 130;
    localparam int TMO  = 5000;
    localparam int RCV  = 650;
    // trig drop to first echo-high sample: two synchronizer flops plus the edge-detect cycle
    localparam int SYNC_LAT = 3;

`ifdef SONAR_EMU_JITTER_EN
    localparam bit JIT = 1'b1;
`else
    localparam bit JIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [7:0] distance_cm;
    logic       echo;
    logic       busy;

    sonar_echo_emu #(
        .TRIG_MIN_CYC (TMIN),
        .BURST_CYC    (BST),
        .CYC_PER_CM   (CPC),
        .TIMEOUT_CYC  (TMO),
        .RECOVER_CYC  (RCV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trig        (trig),
        .distance_cm (distance_cm),
        .echo        (echo),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int rise_cyc;
        int width;
    } exp_t;
    exp_t sbq[$];

    // Pulse monitor: measures every echo pulse and compares it with the oldest expectation.
    logic echo_prev = 1'b0;
    int   rise_c    = 0;
    int   hi_cnt    = 0;
    bit   busy_bad  = 1'b0;
    always @(posedge clk) begin
        #1;
        if (echo && !echo_prev) begin
            rise_c   = cyc;
            hi_cnt   = 0;
            busy_bad = 1'b0;
        end
        if (echo) begin
            hi_cnt++;
            if (!busy) busy_bad = 1'b1;
        end
        if (!echo && echo_prev) begin
            if (sbq.size() == 0) begin
                check("unexpected_echo", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("echo_rise_cycle", rise_c, e.rise_cyc);
                check("echo_width", hi_cnt, e.width);
                check("busy_during_echo", busy_bad, 0);
            end
        end
        echo_prev = echo;
    end

    logic [7:0] lfsr_m = 8'hA5;

    // Call at #1 after an edge; returns the trig-drop cycle and burst delay used.
    task automatic drive_trig(input int w, input int d, input bit acc, input int ew,
                              output int p, output int dl);
        exp_t e;
        trig        = 1'b1;
        distance_cm = 8'(d);
        repeat (w) @(posedge clk);
        #1;
        trig = 1'b0;
        p    = cyc;
        dl   = BST;
        if (acc) begin
            if (JIT) begin
                dl     = BST + int'(lfsr_m[3:0]);
                lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
            end
            e.rise_cyc = p + SYNC_LAT + dl;
            e.width    = ew;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_idle(input int budget, output int c);
        c = -1;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                c = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_echo(input logic val, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (echo == val) break;
            @(posedge clk);
            #1;
        end
        check(name, echo, val);
    endtask

    typedef struct {
        int w;
        int d;
        bit acc;
        int ew;
    } vec_t;
    vec_t vt[8];

    initial begin
        int p, dl, c, bad;

        vt[0] = '{100,  10, 1'b1, 1300};
        vt[1] = '{20,   10, 1'b0, 0};
        vt[2] = '{64,   5,  1'b0, 0};
        vt[3] = '{65,   5,  1'b1, 650};
        vt[4] = '{66,   1,  1'b1, 130};
        vt[5] = '{40,   0,  1'b0, 0};
        vt[6] = '{80,   0,  1'b1, 5000};
        vt[7] = '{3000, 2,  1'b1, 260};

        rst         = 1'b1;
        trig        = 1'b0;
        distance_cm = 8'd0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_echo", echo, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vt[i]) begin
            drive_trig(vt[i].w, vt[i].d, vt[i].acc, vt[i].ew, p, dl);
            wait_idle(20000, c);
            if (vt[i].acc)
                check($sformatf("v%0d_idle_cycle", i), c, p + SYNC_LAT + dl + vt[i].ew + RCV);
            else
                check($sformatf("v%0d_reject_idle_cycle", i), c, p + SYNC_LAT);
            check($sformatf("v%0d_echo_low", i), echo, 0);
            @(posedge clk);
            #1;
        end

        // 255 cm with distance change and extra trigs during ECHO: one full-width pulse only
        drive_trig(100, 255, 1'b1, 33150, p, dl);
        wait_echo(1'b1, 3000, "d255_echo_rise");
        distance_cm = 8'd3;
        for (int k = 0; k < 3; k++) begin
            trig = 1'b1;
            repeat (100) @(posedge clk);
            #1;
            trig = 1'b0;
            repeat (50) @(posedge clk);
            #1;
        end
        wait_idle(40000, c);
        check("d255_idle_cycle", c, p + SYNC_LAT + dl + 33150 + RCV);
        @(posedge clk);
        #1;

        // trig raised during RECOVER and held into IDLE must not start a measurement
        drive_trig(100, 4, 1'b1, 520, p, dl);
        wait_echo(1'b1, 3000, "held_echo_rise");
        wait_echo(1'b0, 3000, "held_echo_fall");
        trig = 1'b1;
        wait_idle(3000, c);
        check("held_idle_cycle", c, p + SYNC_LAT + dl + 520 + RCV);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (busy) bad++;
        end
        trig = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (busy) bad++;
        end
        check("held_trig_no_busy", bad, 0);

        // reset 100 cycles into ECHO, then a normal measurement
        drive_trig(100, 50, 1'b1, 100, p, dl);
        wait_echo(1'b1, 3000, "rst_echo_rise");
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_echo_drop", echo, 0);
        check("rst_busy_drop", busy, 0);
        rst    = 1'b0;
        lfsr_m = 8'hA5;
        @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        drive_trig(100, 2, 1'b1, 260, p, dl);
        wait_idle(5000, c);
        check("post_rst_idle_cycle", c, p + SYNC_LAT + dl + 260 + RCV);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sonar_echo_emu.md
SONAR_ECHO_EMU -- requirements
Module: sonar_echo_emu

Interface
REQ-001 Parameter TRIG_MIN_CYC, default 650, minimum valid trig high width in clk cycles (10 us at 65 MHz).
REQ-002 Parameter BURST_CYC, default 13000, delay from accepted trig fall to echo rise (200 us, 8x40 kHz burst).
REQ-003 Parameter CYC_PER_CM, default 3770, echo high cycles per cm of distance (58 us/cm).
REQ-004 Parameter TIMEOUT_CYC, default 2470000, echo high width for "no object" (38 ms).
REQ-005 Parameter RECOVER_CYC, default 65000, dead time after echo fall before the next trig is accepted (1 ms).
REQ-006 clk  input  1  system clock, 65 MHz; one clock domain only.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 trig  input  1  trigger from the sensor controller; asynchronous to clk.
REQ-009 distance_cm  input  8  emulated target distance in cm; 0 means no object.
REQ-010 echo  output  1  emulated ultrasonic echo pulse.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 trig SHALL pass through a 2-flop synchronizer; all timing below is counted on the synchronized signal (trig_s).
REQ-013 FSM states SHALL be IDLE, TRIG_HI, BURST, ECHO, RECOVER; all outputs registered.
REQ-014 IDLE: trig_s rising edge -> TRIG_HI, width counter cleared to 1.
REQ-015 TRIG_HI: counter increments each cycle trig_s high; on trig_s fall, count >= TRIG_MIN_CYC -> BURST, else -> IDLE with no echo.
REQ-016 distance_cm SHALL be latched on the cycle of the accepted trig_s fall; later changes do not affect the current pulse.
REQ-017 BURST: echo SHALL rise exactly BURST_CYC cycles after the accepted fall cycle; state -> ECHO.
REQ-018 ECHO: echo high for exactly latched_distance*CYC_PER_CM cycles, or TIMEOUT_CYC cycles if latched distance is 0; then echo low, -> RECOVER.
REQ-019 Width product SHALL be computed unsigned at 22 bits (8-bit x 14-bit); no truncation for distance 255 (961350 cycles).
REQ-020 RECOVER: RECOVER_CYC cycles, then -> IDLE; trig_s edges during BURST, ECHO, RECOVER SHALL be ignored.
REQ-021 A trig_s already high on entering IDLE SHALL NOT start a measurement; only a rising edge does.
REQ-022 A trig high longer than any bound SHALL remain in TRIG_HI (counter saturates at TRIG_MIN_CYC) until trig_s falls.

Reset
REQ-023 rst SHALL force state IDLE, echo 0, busy 0, all counters 0, synchronizer flops 0, latched distance 0, on the next clk edge.
REQ-024 rst mid-ECHO SHALL drop echo on the next edge; no partial pulse resumes after rst release.

Configuration
REQ-025 Macro SONAR_EMU_JITTER_EN: when defined, an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset) advances once per accepted trig and its low 4 bits (0-15) are added to the BURST delay.
REQ-026 Without SONAR_EMU_JITTER_EN, the BURST delay is exactly BURST_CYC and no LFSR logic exists.

Structure
REQ-027 Package sonar_pkg SHALL hold the state enum type and the default timing constants (trig min, burst, cycles/cm, timeout, recover) shared with the sensor controller.
REQ-028 Sub-module sync_edge SHALL implement the 2-flop synchronizer plus rise/fall pulse outputs; the rest is flat in sonar_echo_emu.

Verification
REQ-029 trig high 700 cycles, distance_cm=10 -> echo rises 13000 cycles after trig_s fall, high for 37700 cycles, busy high throughout, low after RECOVER.
REQ-030 trig high 100 cycles -> no echo, busy drops to 0 on trig_s fall, FSM back in IDLE.
REQ-031 distance_cm=0, valid trig -> echo high exactly 2470000 cycles (override TIMEOUT_CYC=5000 for speed: 5000).
REQ-032 valid trig with distance_cm=255, then distance_cm=3 and extra trig pulses during ECHO -> single echo of 961350 cycles, extra trigs ignored.
REQ-033 rst asserted 100 cycles into ECHO -> echo 0 and busy 0 next cycle; subsequent valid trig, distance 2 -> normal 7540-cycle echo.
REQ-034 With SONAR_EMU_JITTER_EN, three successive valid trigs -> burst delays in 13000..13015, matching the LFSR sequence from seed 8'hA5.
